// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream multiplexer: FSM states,
// arbitration mode encodings and the grant-width helper.
package stream_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR     = 1;

    function automatic int selWidth(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel
// searching upward from (ptr_i + 1) with wrap-around.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = selWidth(CHANNELS)
) (
    input  logic [SELW-1:0]     ptr_i,
    input  logic [CHANNELS-1:0] req_i,
    output logic [SELW-1:0]     grant_o
);

    logic found;
    int   idx;

    // With no request the pointer is echoed; the caller decides what to hold.
    always_comb begin
        grant_o = ptr_i;
        found   = 1'b0;
        idx     = 0;
        for (int off = 1; off <= CHANNELS; off++) begin
            idx = (int'(ptr_i) + off) % CHANNELS;
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                grant_o = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// Packet-aware N:1 stream multiplexer with a single registered output stage;
// a channel keeps the grant from its first beat until its last beat.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_SELECT,
    localparam int SELW    = selWidth(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS-1:0]       in_last,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [SELW-1:0]           grant,
    output logic                      locked
);

    state_e            state_q;
    logic [SELW-1:0]   grant_q;
    logic [SELW-1:0]   rrPtr_q;
    logic [WIDTH-1:0]  outData_q,  outData_d;
    logic              outValid_q, outValid_d;
    logic              outLast_q,  outLast_d;

    logic [SELW-1:0]   arbGrant;
    logic [SELW-1:0]   selCh;
    logic              selInRange;
    logic              slotFree;
    logic              accept;
    logic [WIDTH-1:0]  chosenData;
    logic              chosenValid;
    logic              chosenLast;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .CHANNELS (CHANNELS),
                .SELW     (SELW)
            ) u_arb (
                .ptr_i   (rrPtr_q),
                .req_i   (in_valid),
                .grant_o (arbGrant)
            );
        end else begin : g_sel
            assign arbGrant = rrPtr_q;
        end
    endgenerate

    // selCh is the channel eligible this cycle; it is what grant registers next.
    always_comb begin
        selCh = grant_q;
        if (state_q == IDLE) begin
            if (MODE == MODE_RR) begin
                selCh = (|in_valid) ? arbGrant : grant_q;
            end else begin
                selCh = sel;
            end
        end

        selInRange  = int'(selCh) < CHANNELS;
        slotFree    = out_ready || !outValid_q;
        chosenData  = '0;
        chosenValid = 1'b0;
        chosenLast  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SELW'(i) == selCh) begin
                chosenData  = in_data[i*WIDTH +: WIDTH];
                chosenValid = in_valid[i];
                chosenLast  = in_last[i];
            end
        end

        in_ready = '0;
        if (rst_n && selInRange && slotFree) begin
            in_ready = CHANNELS'(1) << selCh;
        end
        accept = rst_n && selInRange && slotFree && chosenValid;

        outData_d  = accept ? chosenData : outData_q;
        outLast_d  = accept ? chosenLast : outLast_q;
        outValid_d = accept ? 1'b1 : (out_ready ? 1'b0 : outValid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rrPtr_q    <= SELW'(CHANNELS - 1);
            outData_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            grant_q    <= selCh;
            if (accept) begin
                rrPtr_q <= selCh;
            end
            case (state_q)
                IDLE: if (accept && !chosenLast) state_q <= LOCK;
                LOCK: if (accept && chosenLast)  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign grant     = grant_q;
    assign locked    = (state_q == LOCK);

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux: select mode (4 and 5 channels) and
// round-robin mode share one clock and reset.
module tb_stream_mux;

    typedef struct packed {
        logic [5:0] data;
        logic       last;
        logic [1:0] grant;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Select mode, 4 channels
    logic [1:0]  sel0 = '0;
    logic [23:0] inData0 = '0;
    logic [3:0]  inValid0 = '0, inLast0 = '0, inReady0;
    logic [5:0]  outData0;
    logic        outValid0, outLast0, locked0;
    logic        outReady0 = 1'b0;
    logic [1:0]  grant0;

    // Round-robin mode, 4 channels
    logic [1:0]  sel1 = '0;
    logic [23:0] inData1 = '0;
    logic [3:0]  inValid1 = '0, inLast1 = '0, inReady1;
    logic [5:0]  outData1;
    logic        outValid1, outLast1, locked1;
    logic        outReady1 = 1'b0;
    logic [1:0]  grant1;

    // Select mode, 5 channels
    logic [2:0]  sel2 = '0;
    logic [29:0] inData2 = '0;
    logic [4:0]  inValid2 = '0, inLast2 = '0, inReady2;
    logic [5:0]  outData2;
    logic        outValid2, outLast2, locked2;
    logic        outReady2 = 1'b0;
    logic [2:0]  grant2;

    stream_mux #(.WIDTH(6), .CHANNELS(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .in_data(inData0), .in_valid(inValid0),
        .in_last(inLast0), .in_ready(inReady0), .out_data(outData0), .out_valid(outValid0),
        .out_last(outLast0), .out_ready(outReady0), .grant(grant0), .locked(locked0));

    stream_mux #(.WIDTH(6), .CHANNELS(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel1), .in_data(inData1), .in_valid(inValid1),
        .in_last(inLast1), .in_ready(inReady1), .out_data(outData1), .out_valid(outValid1),
        .out_last(outLast1), .out_ready(outReady1), .grant(grant1), .locked(locked1));

    stream_mux #(.WIDTH(6), .CHANNELS(5), .MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .sel(sel2), .in_data(inData2), .in_valid(inValid2),
        .in_last(inLast2), .in_ready(inReady2), .out_data(outData2), .out_valid(outValid2),
        .out_last(outLast2), .out_ready(outReady2), .grant(grant2), .locked(locked2));

    int    compared = 0;
    int    mismatched = 0;
    beat_t expQ[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] nextRr(input logic [1:0] last, input logic [3:0] req);
        logic [1:0] cand;
        for (int off = 1; off <= 4; off++) begin
            cand = 2'(int'(last) + off);
            if (req[cand]) return cand;
        end
        return last;
    endfunction

    task automatic test_reset;
        inValid0 = 4'b1111;
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if ({outValid0, outLast0, outData0, grant0, locked0} !== 11'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got v=%b l=%b d=%h g=%0d lk=%b want all zero",
                     outValid0, outLast0, outData0, grant0, locked0);
        end
        compared++;
        if ({inReady0, inReady1, inReady2} !== 13'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready got %b/%b/%b want zero", inReady0, inReady1, inReady2);
        end
        compared++;
        if (grant1 !== 2'd0 || outValid1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_rr got g=%0d v=%b want 0/0", grant1, outValid1);
        end
        repeat (2) @(posedge clk);
        inValid0 = '0;
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        beat_t e, got;
        sel0 = 2'd2; inData0 = '0; inData0[12 +: 6] = 6'h2A;
        inValid0 = 4'b0100; inLast0 = 4'b0100; outReady0 = 1'b1;
        expQ.push_back('{data: 6'h2A, last: 1'b1, grant: 2'd2});
        #1;
        compared++;
        if (inReady0 !== 4'b0100) begin
            mismatched++;
            $display("[TB] FAIL single_ready got %b want 0100", inReady0);
        end
        tick();
        inValid0 = '0;
        e = expQ.pop_front();
        got = '{data: outData0, last: outLast0, grant: grant0};
        compared++;
        if (outValid0 !== 1'b1 || got !== e || locked0 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_beat got v=%b %h lk=%b want v=1 %h lk=0", outValid0, got, locked0, e);
        end
        tick();
        compared++;
        if (outValid0 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_drain got v=%b want 0", outValid0);
        end
    endtask

    task automatic test_packet;
        beat_t e, got;
        logic [5:0] ch1Data[3] = '{6'h01, 6'h02, 6'h03};
        sel0 = 2'd1; inData0 = '0; inData0[18 +: 6] = 6'h3F; inLast0 = 4'b1000;
        outReady0 = 1'b1;
        for (int b = 0; b < 3; b++) begin
            inData0[6 +: 6] = ch1Data[b];
            inLast0[1] = (b == 2);
            inValid0 = (b == 0) ? 4'b0010 : 4'b1010;
            if (b == 1) sel0 = 2'd3;
            expQ.push_back('{data: ch1Data[b], last: (b == 2), grant: 2'd1});
            #1;
            compared++;
            if (inReady0 !== 4'b0010) begin
                mismatched++;
                $display("[TB] FAIL packet_ready[%0d] got %b want 0010", b, inReady0);
            end
            tick();
            e = expQ.pop_front();
            got = '{data: outData0, last: outLast0, grant: grant0};
            compared++;
            if (outValid0 !== 1'b1 || got !== e || locked0 !== (b < 2)) begin
                mismatched++;
                $display("[TB] FAIL packet_beat[%0d] got v=%b %h lk=%b want %h lk=%b",
                         b, outValid0, got, locked0, e, (b < 2));
            end
        end
        inValid0 = 4'b1000;
        expQ.push_back('{data: 6'h3F, last: 1'b1, grant: 2'd3});
        tick();
        inValid0 = '0;
        e = expQ.pop_front();
        got = '{data: outData0, last: outLast0, grant: grant0};
        compared++;
        if (outValid0 !== 1'b1 || got !== e) begin
            mismatched++;
            $display("[TB] FAIL packet_regrant got v=%b %h want %h", outValid0, got, e);
        end
        tick();
    endtask

    task automatic test_backpressure;
        beat_t e, got;
        sel0 = 2'd0; inData0 = '0; inData0[0 +: 6] = 6'h15;
        inValid0 = 4'b0001; inLast0 = 4'b0001; outReady0 = 1'b1;
        expQ.push_back('{data: 6'h15, last: 1'b1, grant: 2'd0});
        tick();
        e = expQ.pop_front();
        outReady0 = 1'b0;
        inData0[0 +: 6] = 6'h2B;
        for (int c = 0; c < 4; c++) begin
            #1;
            got = '{data: outData0, last: outLast0, grant: grant0};
            compared++;
            if (inReady0 !== 4'b0000 || outValid0 !== 1'b1 || got !== e) begin
                mismatched++;
                $display("[TB] FAIL bp_hold[%0d] got rdy=%b v=%b %h want rdy=0000 v=1 %h",
                         c, inReady0, outValid0, got, e);
            end
            tick();
        end
        outReady0 = 1'b1;
        expQ.push_back('{data: 6'h2B, last: 1'b1, grant: 2'd0});
        #1;
        compared++;
        if (inReady0 !== 4'b0001) begin
            mismatched++;
            $display("[TB] FAIL bp_release_ready got %b want 0001", inReady0);
        end
        tick();
        inValid0 = '0;
        e = expQ.pop_front();
        got = '{data: outData0, last: outLast0, grant: grant0};
        compared++;
        if (outValid0 !== 1'b1 || got !== e) begin
            mismatched++;
            $display("[TB] FAIL bp_next got v=%b %h want %h", outValid0, got, e);
        end
        tick();
        compared++;
        if (outValid0 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_drain got v=%b want 0", outValid0);
        end
    endtask

    task automatic test_round_robin;
        beat_t e, got;
        logic [1:0] rrPtr = 2'd3;
        logic [1:0] g;
        logic [3:0] patterns[2] = '{4'b1111, 4'b0101};
        int beats[2] = '{5, 3};
        for (int i = 0; i < 4; i++) inData1[i*6 +: 6] = 6'(6'h10 + i);
        inLast1 = 4'b1111; outReady1 = 1'b1;
        for (int p = 0; p < 2; p++) begin
            inValid1 = patterns[p];
            for (int k = 0; k < beats[p]; k++) begin
                g = nextRr(rrPtr, patterns[p]);
                expQ.push_back('{data: 6'(6'h10 + g), last: 1'b1, grant: g});
                #1;
                compared++;
                if (inReady1 !== (4'b0001 << g)) begin
                    mismatched++;
                    $display("[TB] FAIL rr_ready[%0d.%0d] got %b want %b", p, k, inReady1, 4'b0001 << g);
                end
                tick();
                e = expQ.pop_front();
                got = '{data: outData1, last: outLast1, grant: grant1};
                compared++;
                if (outValid1 !== 1'b1 || got !== e || locked1 !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL rr_beat[%0d.%0d] got v=%b %h lk=%b want %h", p, k, outValid1, got, locked1, e);
                end
                rrPtr = g;
            end
        end
        inValid1 = '0;
        tick();
    endtask

    task automatic test_sel_range;
        sel2 = 3'd5; inValid2 = 5'b11111; inLast2 = 5'b11111; outReady2 = 1'b1;
        inData2 = '0; inData2[24 +: 6] = 6'h2E;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++;
            if (inReady2 !== 5'b0 || outValid2 !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL range_sel5[%0d] got rdy=%b v=%b want 00000/0", c, inReady2, outValid2);
            end
            tick();
        end
        sel2 = 3'd4;
        #1;
        compared++;
        if (inReady2 !== 5'b10000) begin
            mismatched++;
            $display("[TB] FAIL range_sel4_ready got %b want 10000", inReady2);
        end
        tick();
        inValid2 = '0;
        compared++;
        if (outValid2 !== 1'b1 || outData2 !== 6'h2E || grant2 !== 3'd4) begin
            mismatched++;
            $display("[TB] FAIL range_sel4_beat got v=%b d=%h g=%0d want 1/2e/4", outValid2, outData2, grant2);
        end
        tick();
    endtask

    task automatic test_reset_mid_packet;
        beat_t e, got;
        sel0 = 2'd1; inData0 = '0; inData0[6 +: 6] = 6'h07;
        inValid0 = 4'b0010; inLast0 = 4'b0000; outReady0 = 1'b0;
        tick();
        outReady0 = 1'b1;
        expQ.push_back('{data: 6'h07, last: 1'b0, grant: 2'd1});
        tick();
        e = expQ.pop_front();
        got = '{data: outData0, last: outLast0, grant: grant0};
        compared++;
        if (outValid0 !== 1'b1 || got !== e || locked0 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_first got v=%b %h lk=%b want %h lk=1", outValid0, got, locked0, e);
        end
        outReady0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (outValid0 !== 1'b0 || locked0 !== 1'b0 || grant0 !== 2'd0 || inReady0 !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_async got v=%b lk=%b g=%0d rdy=%b want 0/0/0/0000",
                     outValid0, locked0, grant0, inReady0);
        end
        inValid0 = '0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        compared++;
        if (locked0 !== 1'b0 || outValid0 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_idle got lk=%b v=%b want 0/0", locked0, outValid0);
        end
        sel0 = 2'd2; inData0[12 +: 6] = 6'h19; inLast0 = 4'b0100; inValid0 = 4'b0100;
        outReady0 = 1'b1;
        expQ.push_back('{data: 6'h19, last: 1'b1, grant: 2'd2});
        tick();
        inValid0 = '0;
        e = expQ.pop_front();
        got = '{data: outData0, last: outLast0, grant: grant0};
        compared++;
        if (outValid0 !== 1'b1 || got !== e || locked0 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_new got v=%b %h lk=%b want %h lk=0", outValid0, got, locked0, e);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_packet();
        test_backpressure();
        test_round_robin();
        test_sel_range();
        test_reset_mid_packet();
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover got %0d want 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
